upsample_2x: RTL and testbench
==============================

# upsample_2x

Streaming 2× nearest-neighbour upsampler: each input pixel of an (OUT_WIDTH/2)×(OUT_WIDTH/2) grayscale frame becomes a 2×2 block of an OUT_WIDTH×OUT_WIDTH output frame. It is the inverse of the 2×2 max-pooling stage and sits on the decoder side of the pixel pipeline. It restores pooled feature maps to display resolution. A single input line buffer lets each input row be replayed, and valid/ready handshakes on both sides absorb the 4× rate expansion.

## Interface
- OUT_WIDTH, 112: output frame width and height in pixels; must be even (112 or 224). IN_WIDTH = OUT_WIDTH/2.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- frame_start  input  1  synchronous frame restart pulse; highest priority.
- pixel_in  input  8  input grayscale pixel.
- pixel_valid_in  input  1  pixel_in valid.
- pixel_ready_out  output  1  block can accept pixel_in this cycle (combinational).
- pixel_out  output  8  output grayscale pixel (registered).
- pixel_valid_out  output  1  pixel_out valid (registered).
- pixel_ready_in  input  1  downstream accepts pixel_out this cycle.
- sof_out  output  1  qualifies pixel_out as output pixel (0,0) of a frame; meaningful only while pixel_valid_out=1.
- frame_done  output  1  one-cycle pulse after the last output pixel of a frame is accepted.

## Operation
- Handshake: an input transfer occurs when pixel_valid_in & pixel_ready_out. An output transfer occurs when pixel_valid_out & pixel_ready_in.
- can_load = !pixel_valid_out | pixel_ready_in. The output register loads only when can_load=1. Otherwise pixel_out, pixel_valid_out and sof_out hold.
- State: FILL / REPLAY, plus a phase bit (first/second copy), col counter (0..IN_WIDTH-1) and row counter (0..IN_WIDTH-1). Counter widths are $clog2(IN_WIDTH).
- FILL, phase 0:
  - pixel_ready_out = can_load.
  - On input transfer: pixel_out←pixel_in, line_buf[col]←pixel_in, hold←pixel_in, pixel_valid_out←1, phase←1.
  - No input and can_load: pixel_valid_out←0.
- FILL, phase 1:
  - pixel_ready_out = 0.
  - On can_load: pixel_out←hold, phase←0, col++.
  - At col=IN_WIDTH-1: col←0 and state←REPLAY.
- REPLAY:
  - pixel_ready_out = 0.
  - Each can_load emits line_buf[col] with pixel_valid_out=1, alternating phase. After phase 1, col++.
  - After phase 1 of col=IN_WIDTH-1: col←0, state←FILL, and row++.
  - If row was IN_WIDTH-1, row←0; the frame is complete.
- sof_out←1 when loading the phase-0 copy at row 0, col 0 in FILL. Otherwise it is cleared on every load.
- frame_done←1 for one cycle on the cycle after the output transfer of the final REPLAY pixel (row IN_WIDTH-1, col IN_WIDTH-1, phase 1). After that the block is in FILL, row 0, ready for the next frame without needing frame_start.
- frame_start: state←FILL, phase/col/row←0, pixel_valid_out←0, sof_out←0, frame_done←0.
  - A pixel presented in the same cycle is not accepted; pixel_ready_out=0 while frame_start=1.
  - Partially emitted data is discarded.
- Line buffer contents are not reset; they are always written before being read.
- Pixel values pass unmodified; there is no arithmetic on data.

## Timing
- Reset values: pixel_out=0, pixel_valid_out=0, sof_out=0, frame_done=0; state FILL, all counters 0. pixel_ready_out=1 immediately after reset if frame_start=0.
- Latency: input transfer at cycle t gives its first copy on pixel_out at t+1 and its second copy at the next load (t+2 with pixel_ready_in held high).
- Throughput, with pixel_ready_in=1 and continuous input:
  - One output pixel every cycle.
  - Input accepted every 2nd cycle during FILL rows, never during REPLAY rows.
  - A full frame takes OUT_WIDTH² cycles plus 1.
- Backpressure: with pixel_ready_in=0 while pixel_valid_out=1, no state changes and pixel_ready_out=0.
- The input side may stall in FILL phase 0 indefinitely. pixel_valid_out drops to 0 on the next can_load; no bubble-induced duplication or loss.
- rst mid-frame clears everything asynchronously. The next frame starts from row 0 col 0.

## Test plan
- Reset, OUT_WIDTH=8, feed 4×4 ramp 0..15, pixel_ready_in=1:
  - Output rows 0,1 are 0,0,1,1,2,2,3,3; rows 6,7 are 12,12,13,13,14,14,15,15.
  - 64 outputs total, sof_out only on the first, and a single frame_done pulse.
- Same stimulus with pixel_ready_in toggled pseudo-randomly: identical 64-value sequence; pixel_out stable while stalled.
- Input valid gaps (valid 1 in 3 cycles) with pixel_ready_in=1: correct sequence, pixel_valid_out low in gap cycles, no input accepted during REPLAY.
- frame_start asserted mid-row 2 together with pixel_valid_in=1:
  - That pixel is not accepted and pixel_valid_out=0 next cycle.
  - A new frame ramp 100..115 outputs 100,100,101,… with sof_out on the first pixel.
- Async rst pulse mid-REPLAY: all outputs 0 on the following edge, pixel_ready_out=1. The next frame is correct.
- Two back-to-back frames without frame_start: second frame output correct, sof_out once per frame, frame_done twice.

Source files
------------

// File: rtl/upsample_2x.sv
// Streaming 2x nearest-neighbour upsampler: each input pixel becomes a 2x2 output block.
// One input row is captured in a line buffer while emitted twice per pixel, then replayed.
module upsample_2x #(
  parameter int OUT_WIDTH = 112
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic [7:0] pixel_in,
  input  logic       pixel_valid_in,
  output logic       pixel_ready_out,
  output logic [7:0] pixel_out,
  output logic       pixel_valid_out,
  input  logic       pixel_ready_in,
  output logic       sof_out,
  output logic       frame_done
);

  localparam int IN_WIDTH = OUT_WIDTH / 2;
  localparam int CW = $clog2(IN_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);

  typedef enum logic {FILL, REPLAY} state_t;

  state_t        state, state_nxt;
  logic          phase, phase_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [CW-1:0] row, row_nxt;
  logic [7:0]    hold, hold_nxt;
  logic [7:0]    pout_nxt;
  logic          vout_nxt, sof_nxt, done_nxt;
  // Marks that the output register holds the final pixel of the frame.
  logic          last_q, last_nxt;
  logic          can_load, in_xfer;

  logic [7:0] line_buf [IN_WIDTH];

  assign can_load        = !pixel_valid_out || pixel_ready_in;
  assign pixel_ready_out = !frame_start && (state == FILL) && !phase && can_load;
  assign in_xfer         = pixel_valid_in && pixel_ready_out;

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    col_nxt   = col;
    row_nxt   = row;
    hold_nxt  = hold;
    pout_nxt  = pixel_out;
    vout_nxt  = pixel_valid_out;
    sof_nxt   = sof_out;
    last_nxt  = last_q;
    done_nxt  = pixel_valid_out && pixel_ready_in && last_q;

    if (frame_start) begin
      state_nxt = FILL;
      phase_nxt = 1'b0;
      col_nxt   = '0;
      row_nxt   = '0;
      vout_nxt  = 1'b0;
      sof_nxt   = 1'b0;
      last_nxt  = 1'b0;
      done_nxt  = 1'b0;
    end else if (can_load) begin
      case (state)
        FILL: begin
          if (!phase) begin
            if (in_xfer) begin
              pout_nxt  = pixel_in;
              hold_nxt  = pixel_in;
              vout_nxt  = 1'b1;
              sof_nxt   = (row == '0) && (col == '0);
              last_nxt  = 1'b0;
              phase_nxt = 1'b1;
            end else begin
              vout_nxt = 1'b0;
              sof_nxt  = 1'b0;
              last_nxt = 1'b0;
            end
          end else begin
            pout_nxt  = hold;
            vout_nxt  = 1'b1;
            sof_nxt   = 1'b0;
            last_nxt  = 1'b0;
            phase_nxt = 1'b0;
            if (col == LAST) begin
              col_nxt   = '0;
              state_nxt = REPLAY;
            end else begin
              col_nxt = col + 1'b1;
            end
          end
        end
        REPLAY: begin
          pout_nxt  = line_buf[col];
          vout_nxt  = 1'b1;
          sof_nxt   = 1'b0;
          phase_nxt = !phase;
          last_nxt  = phase && (col == LAST) && (row == LAST);
          if (phase) begin
            if (col == LAST) begin
              col_nxt   = '0;
              state_nxt = FILL;
              row_nxt   = (row == LAST) ? '0 : row + 1'b1;
            end else begin
              col_nxt = col + 1'b1;
            end
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= FILL;
      phase           <= 1'b0;
      col             <= '0;
      row             <= '0;
      hold            <= '0;
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
      sof_out         <= 1'b0;
      last_q          <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      state           <= state_nxt;
      phase           <= phase_nxt;
      col             <= col_nxt;
      row             <= row_nxt;
      hold            <= hold_nxt;
      pixel_out       <= pout_nxt;
      pixel_valid_out <= vout_nxt;
      sof_out         <= sof_nxt;
      last_q          <= last_nxt;
      frame_done      <= done_nxt;
    end
  end

  // Contents need no reset: every entry is written in FILL before REPLAY reads it.
  always_ff @(posedge clk) begin
    if (in_xfer) line_buf[col] <= pixel_in;
  end

endmodule

// File: tb/tb_upsample_2x.sv
// Scoreboard bench for upsample_2x at OUT_WIDTH=8 (4x4 input frames).
module tb_upsample_2x;

  localparam int OW = 8;
  localparam int IW = OW / 2;

  typedef struct {
    logic [7:0] pix;
    logic       sof;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic [7:0] pixel_in;
  logic       pixel_valid_in;
  logic       pixel_ready_out;
  logic [7:0] pixel_out;
  logic       pixel_valid_out;
  logic       pixel_ready_in;
  logic       sof_out;
  logic       frame_done;

  upsample_2x #(.OUT_WIDTH(OW)) dut (
    .clk             (clk),
    .rst             (rst),
    .frame_start     (frame_start),
    .pixel_in        (pixel_in),
    .pixel_valid_in  (pixel_valid_in),
    .pixel_ready_out (pixel_ready_out),
    .pixel_out       (pixel_out),
    .pixel_valid_out (pixel_valid_out),
    .pixel_ready_in  (pixel_ready_in),
    .sof_out         (sof_out),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic [7:0] rowbuf [IW];
  int   in_cnt = 0;
  int   out_cnt = 0, sof_cnt = 0, done_cnt = 0, idle_cnt = 0;
  bit   done_exp = 0, stall_prev = 0, rand_ready = 0;
  logic [7:0] prev_pix = '0;
  int   gap = 0;

  // Monitor: pops the scoreboard on each output transfer, checks stalls and frame_done timing.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      done_exp   = 0;
      stall_prev = 0;
    end else begin
      checks++;
      if (frame_done !== done_exp) begin
        errors++;
        $display("FAIL frame_done_timing: got %b expected %b at %0t", frame_done, done_exp, $time);
      end
      if (frame_done === 1'b1) done_cnt++;
      done_exp = 0;
      if (stall_prev) begin
        checks++;
        if (pixel_valid_out !== 1'b1 || pixel_out !== prev_pix) begin
          errors++;
          $display("FAIL stall_hold: got valid %b pixel %0d expected valid 1 pixel %0d", pixel_valid_out, pixel_out, prev_pix);
        end
      end
      if (pixel_valid_out !== 1'b1) idle_cnt++;
      if (pixel_valid_out === 1'b1 && pixel_ready_in === 1'b1) begin
        out_cnt++;
        if (sof_out === 1'b1) sof_cnt++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got pixel %0d sof %b with empty scoreboard", pixel_out, sof_out);
        end else begin
          e = q.pop_front();
          if (pixel_out !== e.pix || sof_out !== e.sof) begin
            errors++;
            $display("FAIL out_pixel: got pixel %0d sof %b expected pixel %0d sof %b", pixel_out, sof_out, e.pix, e.sof);
          end
          if (e.last) done_exp = 1;
        end
      end
      stall_prev = (pixel_valid_out === 1'b1) && (pixel_ready_in !== 1'b1);
      prev_pix   = pixel_out;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) pixel_ready_in = 1'($urandom_range(0, 1));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one pixel and, on acceptance, push the outputs it implies (plus the row replay on a row's last pixel).
  task automatic send_pixel(input logic [7:0] v);
    int n;
    int col, row;
    exp_t e;
    repeat (gap) begin @(posedge clk); #1; end
    pixel_in = v;
    pixel_valid_in = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (pixel_ready_out === 1'b1) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: pixel %0d not accepted within %0d cycles", v, n);
        pixel_valid_in = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    col = in_cnt % IW;
    row = in_cnt / IW;
    rowbuf[col] = v;
    e.pix = v; e.sof = (in_cnt == 0); e.last = 1'b0;
    q.push_back(e);
    e.sof = 1'b0;
    q.push_back(e);
    if (col == IW - 1) begin
      for (int c = 0; c < IW; c++) begin
        e.pix = rowbuf[c]; e.sof = 1'b0; e.last = 1'b0;
        q.push_back(e);
        e.last = (row == IW - 1) && (c == IW - 1);
        q.push_back(e);
      end
    end
    in_cnt = (in_cnt + 1) % (IW * IW);
    @(posedge clk); #1;
    pixel_valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 2000) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending outputs expected 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_start = 1'b0; pixel_in = '0; pixel_valid_in = 1'b0; pixel_ready_in = 1'b1;
    #12;
    @(negedge clk);
    checks++;
    if (pixel_out !== 8'd0) begin errors++; $display("FAIL reset_pixel_out: got %0d expected 0", pixel_out); end
    checks++;
    if (pixel_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pixel_valid_out); end
    checks++;
    if (sof_out !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL reset_flags: got sof %b done %b expected 0 0", sof_out, frame_done); end
    checks++;
    if (pixel_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", pixel_ready_out); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    int o0 = out_cnt, s0 = sof_cnt, d0 = done_cnt;
    send_pixel(8'd0);
    checks++;
    if (pixel_valid_out !== 1'b1 || pixel_out !== 8'd0) begin
      errors++;
      $display("FAIL first_latency: got valid %b pixel %0d expected valid 1 pixel 0", pixel_valid_out, pixel_out);
    end
    for (int i = 1; i < 16; i++) send_pixel(8'(i));
    wait_drain();
    checks++;
    if (out_cnt - o0 != OW * OW) begin errors++; $display("FAIL ramp_count: got %0d expected %0d", out_cnt - o0, OW * OW); end
    checks++;
    if (sof_cnt - s0 != 1) begin errors++; $display("FAIL ramp_sof: got %0d expected 1", sof_cnt - s0); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL ramp_done: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_rand_ready();
    int o0 = out_cnt, d0 = done_cnt;
    rand_ready = 1;
    for (int i = 0; i < 16; i++) send_pixel(8'(i));
    wait_drain();
    rand_ready = 0;
    @(posedge clk); #1;
    pixel_ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_cnt - o0 != OW * OW) begin errors++; $display("FAIL rand_count: got %0d expected %0d", out_cnt - o0, OW * OW); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL rand_done: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_gaps();
    int o0 = out_cnt, i0 = idle_cnt;
    gap = 2;
    for (int i = 0; i < 16; i++) send_pixel(8'(50 + i));
    gap = 0;
    wait_drain();
    checks++;
    if (out_cnt - o0 != OW * OW) begin errors++; $display("FAIL gap_count: got %0d expected %0d", out_cnt - o0, OW * OW); end
    checks++;
    if (idle_cnt - i0 < 16) begin errors++; $display("FAIL gap_idle: got %0d idle cycles expected at least 16", idle_cnt - i0); end
  endtask

  task automatic test_frame_start();
    int s0, d0;
    for (int i = 0; i < 10; i++) send_pixel(8'(i));
    frame_start = 1'b1;
    pixel_valid_in = 1'b1;
    pixel_in = 8'd55;
    @(negedge clk);
    checks++;
    if (pixel_ready_out !== 1'b0) begin errors++; $display("FAIL fs_ready: got %b expected 0", pixel_ready_out); end
    @(posedge clk); #1;
    frame_start = 1'b0;
    pixel_valid_in = 1'b0;
    checks++;
    if (pixel_valid_out !== 1'b0 || sof_out !== 1'b0) begin
      errors++;
      $display("FAIL fs_clear: got valid %b sof %b expected 0 0", pixel_valid_out, sof_out);
    end
    q.delete();
    in_cnt = 0;
    s0 = sof_cnt; d0 = done_cnt;
    for (int i = 0; i < 16; i++) send_pixel(8'(100 + i));
    wait_drain();
    checks++;
    if (sof_cnt - s0 != 1) begin errors++; $display("FAIL fs_sof: got %0d expected 1", sof_cnt - s0); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL fs_done: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int s0, d0;
    for (int i = 0; i < 8; i++) send_pixel(8'(i));
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (pixel_out !== 8'd0 || pixel_valid_out !== 1'b0 || sof_out !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got pixel %0d valid %b sof %b done %b expected all 0", pixel_out, pixel_valid_out, sof_out, frame_done);
    end
    checks++;
    if (pixel_ready_out !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", pixel_ready_out); end
    q.delete();
    in_cnt = 0;
    #7;
    rst = 1'b0;
    @(posedge clk); #1;
    s0 = sof_cnt; d0 = done_cnt;
    for (int i = 0; i < 16; i++) send_pixel(8'(15 - i));
    wait_drain();
    checks++;
    if (sof_cnt - s0 != 1 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL rst_mid_frame: got sof %0d done %0d expected 1 1", sof_cnt - s0, done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int o0 = out_cnt, s0 = sof_cnt, d0 = done_cnt;
    for (int i = 0; i < 16; i++) send_pixel(8'(i));
    for (int i = 0; i < 16; i++) send_pixel(8'(200 + i));
    wait_drain();
    checks++;
    if (out_cnt - o0 != 2 * OW * OW) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", out_cnt - o0, 2 * OW * OW); end
    checks++;
    if (sof_cnt - s0 != 2) begin errors++; $display("FAIL b2b_sof: got %0d expected 2", sof_cnt - s0); end
    checks++;
    if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done: got %0d expected 2", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_rand_ready();
    test_gaps();
    test_frame_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
